// File: rtl/proc_pkg.sv
// Purpose : shared types and constants for the 8-bit pipelined processor front end.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: if_state_t fetch FSM encoding (IF_LOAD only when IF_PROG_LOAD_EN is defined),
//           NOP_CODE_DEFAULT, 2-bit opcode constants, default program image IMEM_INIT.
package proc_pkg;

`ifdef IF_PROG_LOAD_EN
  typedef enum logic [1:0] {
    IF_BOOT = 2'd0,
    IF_RUN  = 2'd1,
    IF_LOAD = 2'd2
  } if_state_t;
`else
  typedef enum logic [1:0] {
    IF_BOOT = 2'd0,
    IF_RUN  = 2'd1
  } if_state_t;
`endif

  // Opcode 00 with both register fields 0 is MOV R0<-R0, a harmless bubble.
  localparam logic [7:0] NOP_CODE_DEFAULT = 8'h00;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b11;

  // Default program; every word not listed is a NOP.
  localparam logic [7:0] IMEM_INIT [0:255] = '{
    0: 8'h48,  1: 8'h51,  2: 8'hC0,  3: 8'h4A,  4: 8'h13,  5: 8'h62,  6: 8'h27,  7: 8'h75,
    8: 8'h39,  9: 8'h8E, 10: 8'h1C, 11: 8'hD5, 12: 8'h6B, 13: 8'hA3, 14: 8'hF0, 15: 8'h0F,
   16: 8'h5E, 17: 8'h33, 18: 8'h87, 19: 8'hC4, 20: 8'h29, 21: 8'h9B, 22: 8'hB6, 23: 8'h44,
   24: 8'hE1, 25: 8'h17, 26: 8'h7C, 27: 8'hA8, 28: 8'h35, 29: 8'hD2, 30: 8'h6F, 31: 8'hC9,
   33: 8'hEE,
    default: 8'h00
  };

endpackage

// File: rtl/instr_mem.sv
// Purpose : instruction memory, IMEM_DEPTH words of 8 bits, address wraps modulo IMEM_DEPTH.
// Latency : read is combinational (0 cycles); write (IF_PROG_LOAD_EN only) lands on the clk edge.
// Backpressure: none, always ready.
// Ports   : rd_addr/rd_dat read port; with IF_PROG_LOAD_EN also clk, Reset (async, active-low,
//           restores IMEM_INIT), wr_en/wr_addr/wr_dat synchronous write port.
module instr_mem
  import proc_pkg::*;
#(
  parameter int IMEM_DEPTH = 32
) (
`ifdef IF_PROG_LOAD_EN
  input  logic       clk,
  input  logic       Reset,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_dat,
`endif
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_dat
);

`ifdef IF_PROG_LOAD_EN
  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [7:0]    mem [IMEM_DEPTH];
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  // Modulo by a power of two reduces to keeping the low address bits.
  assign rd_idx = AW'(int'(rd_addr) % IMEM_DEPTH);
  assign wr_idx = AW'(int'(wr_addr) % IMEM_DEPTH);
  assign rd_dat = mem[rd_idx];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < IMEM_DEPTH; i++) mem[i] <= IMEM_INIT[i];
    end else if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end
`else
  logic [7:0] rom_idx;

  assign rom_idx = 8'(int'(rd_addr) % IMEM_DEPTH);
  assign rd_dat  = IMEM_INIT[rom_idx];
`endif

endmodule

// File: rtl/instruction_fetch.sv
// Purpose : IF stage - owns the PC, fetches imem[PC] and presents {PC, code} to IF/ID each cycle.
// Latency : 0-cycle fetch; 1 bubble after reset release (BOOT) and 1 bubble per jump.
// Backpressure: Stall freezes PC and outputs; Jump_en outranks Stall; Prog_we outranks both.
// Ports   : clk, Reset (async active-low), Stall, Jump_en, Jump_target[7:0] in;
//           Instruction_Code[7:0], PC_instFetch[7:0], Fetch_valid out;
//           Prog_we, Prog_addr[7:0], Prog_data[7:0] in only when IF_PROG_LOAD_EN is defined.
module instruction_fetch
  import proc_pkg::*;
#(
  parameter int         IMEM_DEPTH = 32,
  parameter logic [7:0] NOP_CODE   = NOP_CODE_DEFAULT
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Stall,
  input  logic       Jump_en,
  input  logic [7:0] Jump_target,
`ifdef IF_PROG_LOAD_EN
  input  logic       Prog_we,
  input  logic [7:0] Prog_addr,
  input  logic [7:0] Prog_data,
`endif
  output logic [7:0] Instruction_Code,
  output logic [7:0] PC_instFetch,
  output logic       Fetch_valid
);

  if_state_t  state;
  if_state_t  state_nxt;
  logic [7:0] pc;
  logic [7:0] pc_nxt;
  logic [7:0] imem_dat;
  logic       fetch_live;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IF_BOOT: begin
        state_nxt = IF_RUN;
        pc_nxt    = 8'h00;
      end
      IF_RUN: begin
        if (Jump_en)     pc_nxt = Jump_target;
        else if (!Stall) pc_nxt = pc + 8'd1;   // 8-bit add wraps FF -> 00
      end
`ifdef IF_PROG_LOAD_EN
      IF_LOAD: begin
        // Reached only once Prog_we has dropped; restart through BOOT from 0.
        state_nxt = IF_BOOT;
        pc_nxt    = 8'h00;
      end
`endif
      default: begin
        state_nxt = IF_BOOT;
        pc_nxt    = 8'h00;
      end
    endcase
`ifdef IF_PROG_LOAD_EN
    // A program write from any state takes over the stage.
    if (Prog_we) begin
      state_nxt = IF_LOAD;
      pc_nxt    = 8'h00;
    end
`endif
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IF_BOOT;
      pc    <= 8'h00;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  instr_mem #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_imem (
`ifdef IF_PROG_LOAD_EN
    .clk     (clk),
    .Reset   (Reset),
    .wr_en   (Prog_we),
    .wr_addr (Prog_addr),
    .wr_dat  (Prog_data),
`endif
    .rd_addr (pc),
    .rd_dat  (imem_dat)
  );

  // A jump squashes the instruction being fetched so IF/ID captures a NOP,
  // while PC_instFetch still reports the squashed slot's PC.
  assign fetch_live       = (state == IF_RUN) && !Jump_en;
  assign Instruction_Code = fetch_live ? imem_dat : NOP_CODE;
  assign PC_instFetch     = pc;
  assign Fetch_valid      = fetch_live;

endmodule
